// File: rtl/grid_painter.sv
// ============================================================================
// grid_painter
// ----------------------------------------------------------------------------
// Splits the visible raster into a COLS x ROWS grid of CELL_W x CELL_H cells.
// Each cell has a writable RGB palette entry. A step-driven sequencer lights
// cells in index order (k = row*COLS + col). The display uses a copy of the
// lit count that is taken only at frame_start, so a frame never tears.
//
// Optional feature macro: GRID_BORDER_EN
//   When defined, in-grid pixels on a cell's first column or first row
//   output BORDER_RGB whatever the lit state is.
//
// Ports
//   clk, reset            pixel clock, synchronous active-high reset
//   x, y, active          raster position and visible-area flag
//   frame_start           one-cycle pulse at start of frame
//   step, clear           sequencer controls (clear has priority)
//   wr_en, wr_idx,
//   wr_r, wr_g, wr_b      palette write port
//   r, g, b               pixel colour, 2 cycles after x/y/active
//   lit, full             sequencer count and "all cells lit" flag
// ============================================================================
module grid_painter #(
    parameter int          COLS       = 2,
    parameter int          ROWS       = 2,
    parameter int          CELL_W     = 320,
    parameter int          CELL_H     = 240,
    parameter int          COLOR_W    = 8,
    parameter logic [23:0] BORDER_RGB = 24'hFFFFFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic               active,
    input  logic               frame_start,
    input  logic               step,
    input  logic               clear,
    input  logic               wr_en,
    input  logic [3:0]         wr_idx,
    input  logic [COLOR_W-1:0] wr_r,
    input  logic [COLOR_W-1:0] wr_g,
    input  logic [COLOR_W-1:0] wr_b,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b,
    output logic [4:0]         lit,
    output logic               full
);

    localparam int          N      = COLS * ROWS;
    localparam logic [4:0]  N5     = 5'(N);
    localparam logic [31:0] GRID_W = 32'(COLS * CELL_W);
    localparam logic [31:0] GRID_H = 32'(ROWS * CELL_H);

    typedef enum logic [1:0] {IDLE, REVEAL, FULL} seq_state_t;

    seq_state_t state;
    logic [4:0] lit_disp;

    // ------------------------------------------------------------------
    // Reveal sequencer and frame-synchronous display copy
    // ------------------------------------------------------------------
    // NOTE: all clocked state uses non-blocking assignments so every
    // register samples pre-edge values; lit_disp therefore picks up the
    // old lit even when step changes lit on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            lit      <= '0;
            full     <= 1'b0;
            lit_disp <= '0;
        end else begin
            if (frame_start)
                lit_disp <= lit;

            if (clear) begin
                state <= IDLE;
                lit   <= '0;
                full  <= 1'b0;
            end else if (step) begin
                case (state)
                    IDLE: begin
                        lit   <= 5'd1;
                        state <= (N == 1) ? FULL : REVEAL;
                        full  <= (N == 1);
                    end
                    REVEAL: begin
                        lit <= lit + 5'd1;
                        if (lit + 5'd1 == N5) begin
                            state <= FULL;
                            full  <= 1'b1;
                        end
                    end
                    default: ;  // FULL: further steps are ignored
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Palette: 16 slots addressable by wr_idx, only the first N writable
    // ------------------------------------------------------------------
    logic [3*COLOR_W-1:0] palette [16];

    // NOTE: the palette is reset entry by entry because cells must read
    // back as black after reset; this costs a reset fan-out on every
    // entry, so it is not done for memories that can power up random.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++)
                palette[i] <= '0;
        end else if (wr_en && ({1'b0, wr_idx} < N5)) begin
            palette[wr_idx] <= {wr_r, wr_g, wr_b};
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: cell coordinates, in-grid and active flags
    // ------------------------------------------------------------------
    logic [31:0] x32, y32;
    logic [2:0]  col_s1, row_s1;
    logic        in_grid_s1, act_s1;

    assign x32 = {22'd0, x};
    assign y32 = {22'd0, y};

`ifdef GRID_BORDER_EN
    logic border_s1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            col_s1     <= '0;
            row_s1     <= '0;
            in_grid_s1 <= 1'b0;
            act_s1     <= 1'b0;
`ifdef GRID_BORDER_EN
            border_s1  <= 1'b0;
`endif
        end else begin
            // Out-of-grid pixels may truncate col/row; in_grid masks them.
            col_s1     <= 3'(x32 / 32'(CELL_W));
            row_s1     <= 3'(y32 / 32'(CELL_H));
            in_grid_s1 <= (x32 < GRID_W) && (y32 < GRID_H);
            act_s1     <= active;
`ifdef GRID_BORDER_EN
            border_s1  <= (x32 % 32'(CELL_W) == 0) || (y32 % 32'(CELL_H) == 0);
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: palette lookup, visibility, output registers
    // ------------------------------------------------------------------
    logic [3:0]           cell_idx;
    logic                 visible;
    logic [3*COLOR_W-1:0] entry;

    assign cell_idx = 4'(row_s1) * 4'(COLS) + 4'(col_s1);
    assign visible  = {1'b0, cell_idx} < lit_disp;
    // Registered palette: a same-cycle write is seen one cycle later.
    assign entry    = palette[cell_idx];

    always_ff @(posedge clk) begin
        if (reset || !act_s1 || !in_grid_s1) begin
            r <= '0;
            g <= '0;
            b <= '0;
        end
`ifdef GRID_BORDER_EN
        else if (border_s1) begin
            r <= COLOR_W'(BORDER_RGB[23:16]);
            g <= COLOR_W'(BORDER_RGB[15:8]);
            b <= COLOR_W'(BORDER_RGB[7:0]);
        end
`endif
        else if (visible) begin
            r <= entry[3*COLOR_W-1:2*COLOR_W];
            g <= entry[2*COLOR_W-1:COLOR_W];
            b <= entry[COLOR_W-1:0];
        end else begin
            r <= '0;
            g <= '0;
            b <= '0;
        end
    end

endmodule
